ctrl_wb_seq: RTL and testbench

Write-back sequencer for the SMAC output path. It steps the output mux counter (max_val / cnt_load / cnt_clear / act_wb) and the ReLU group select. It also streams one output word per accepted cycle to the output memory, honouring memory back-pressure. It sits between the top-level layer FSM, which issues start and receives done, and the output mux counter, output mux and output memory write port.

---
 rtl/ctrl_wb_seq.sv | 198 +++++++++++++++++++
 tb/tb_ctrl_wb_seq.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_wb_seq.sv
// ----------------------------------------------------------------------------
// ctrl_wb_seq : write-back sequencer for the SMAC output path.
//
// Takes a start from the layer FSM and configures the output mux counter
// with a load strobe and then a clear strobe. It then streams one output word
// per accepted cycle to the output memory. While streaming it steps the mux
// counter (act_wb) and the ReLU group select. Memory back-pressure comes in on
// mem_ready. The pass ends with a one-cycle done pulse.
//
// Ports
//   clk, rst_n        : clock (rising edge), asynchronous active-low reset
//   start             : begin a pass (sampled in IDLE only)
//   abort             : synchronous cancel in any non-IDLE state
//   n_mux[2:0]        : mux inputs per group, clamped to 1..4, latched on start
//   n_groups[GRP_W-1:0]: group count, 0 encodes 2^GRP_W, latched on start
//   base_addr         : first write address, latched on start
//   mem_ready         : output memory accepts the word this cycle
//   busy, done        : status / completion pulse
//   cnt_load, max_val : load strobe and clamped max value to the mux counter
//   cnt_clear, act_wb : clear / advance strobes to the mux counter
//   sel_mux_out       : mirrored output mux select
//   sel_relu          : current group index
//   wr_en, wr_addr    : output memory write request and address
// ----------------------------------------------------------------------------
module ctrl_wb_seq #(
   parameter int ADDR_W = 8,
   parameter int GRP_W  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [2:0]        n_mux,
   input  logic [GRP_W-1:0]  n_groups,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              mem_ready,
   output logic              busy,
   output logic              done,
   output logic              cnt_load,
   output logic [2:0]        max_val,
   output logic              cnt_clear,
   output logic              act_wb,
   output logic [1:0]        sel_mux_out,
   output logic [GRP_W-1:0]  sel_relu,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_CLEAR = 3'd2,
      S_WB    = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t            state_reg,     state_next;
   logic [2:0]        n_mux_c_reg,   n_mux_c_next;
   logic [GRP_W-1:0]  n_groups_reg,  n_groups_next;
   logic [ADDR_W-1:0] base_addr_reg, base_addr_next;
   logic [1:0]        mux_idx_reg,   mux_idx_next;
   logic [GRP_W-1:0]  grp_idx_reg,   grp_idx_next;
   logic [ADDR_W-1:0] wr_addr_reg,   wr_addr_next;

   logic [2:0]        n_mux_clamped;
   logic              last_mux;
   logic              last_grp;

   // Out-of-range mux counts are clamped into 1..4 before they reach the counter.
   always_comb begin
      n_mux_clamped = n_mux;
      if (n_mux == 3'd0) begin
         n_mux_clamped = 3'd1;
      end else if (n_mux > 3'd4) begin
         n_mux_clamped = 3'd4;
      end
   end

   // n_groups of 0 stands for 2^GRP_W groups. Subtracting 1 modulo 2^GRP_W
   // gives the last group index for every encoding, including that one.
   assign last_mux = ({1'b0, mux_idx_reg} == (n_mux_c_reg - 3'd1));
   assign last_grp = (grp_idx_reg == (n_groups_reg - GRP_W'(1)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= S_IDLE;
         n_mux_c_reg   <= '0;
         n_groups_reg  <= '0;
         base_addr_reg <= '0;
         mux_idx_reg   <= '0;
         grp_idx_reg   <= '0;
         wr_addr_reg   <= '0;
      end else begin
         state_reg     <= state_next;
         n_mux_c_reg   <= n_mux_c_next;
         n_groups_reg  <= n_groups_next;
         base_addr_reg <= base_addr_next;
         mux_idx_reg   <= mux_idx_next;
         grp_idx_reg   <= grp_idx_next;
         wr_addr_reg   <= wr_addr_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      n_mux_c_next   = n_mux_c_reg;
      n_groups_next  = n_groups_reg;
      base_addr_next = base_addr_reg;
      mux_idx_next   = mux_idx_reg;
      grp_idx_next   = grp_idx_reg;
      wr_addr_next   = wr_addr_reg;
      done           = 1'b0;
      cnt_load       = 1'b0;
      cnt_clear      = 1'b0;
      act_wb         = 1'b0;
      wr_en          = 1'b0;

      case (state_reg)
         S_IDLE: begin
            // abort is ignored here, so start wins when both are high.
            if (start) begin
               n_mux_c_next   = n_mux_clamped;
               n_groups_next  = n_groups;
               base_addr_next = base_addr;
               state_next     = S_LOAD;
            end
         end

         S_LOAD: begin
            if (abort) begin
               cnt_clear  = 1'b1;
               state_next = S_IDLE;
            end else begin
               cnt_load   = 1'b1;
               state_next = S_CLEAR;
            end
         end

         S_CLEAR: begin
            cnt_clear = 1'b1;
            if (abort) begin
               state_next = S_IDLE;
            end else begin
               mux_idx_next = '0;
               grp_idx_next = '0;
               wr_addr_next = base_addr_reg;
               state_next   = S_WB;
            end
         end

         S_WB: begin
            if (abort) begin
               // Abort overrides the accept: nothing is written and the
               // counter is cleared so it is clean for the next pass.
               cnt_clear  = 1'b1;
               state_next = S_IDLE;
            end else begin
               wr_en = 1'b1;
               if (mem_ready) begin
                  act_wb       = 1'b1;
                  wr_addr_next = wr_addr_reg + ADDR_W'(1);
                  if (last_mux) begin
                     // Group wrap happens in the same accept cycle, so there
                     // is no bubble between groups.
                     mux_idx_next = '0;
                     grp_idx_next = grp_idx_reg + GRP_W'(1);
                     if (last_grp) begin
                        state_next = S_DONE;
                     end
                  end else begin
                     mux_idx_next = mux_idx_reg + 2'd1;
                  end
               end
            end
         end

         S_DONE: begin
            if (abort) begin
               cnt_clear = 1'b1;
            end else begin
               done = 1'b1;
            end
            state_next = S_IDLE;
         end

         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   assign busy        = (state_reg != S_IDLE);
   assign max_val     = n_mux_c_reg;
   assign sel_mux_out = mux_idx_reg;
   assign sel_relu    = grp_idx_reg;
   assign wr_addr     = wr_addr_reg;

endmodule

// File: tb/tb_ctrl_wb_seq.sv
// ----------------------------------------------------------------------------
// tb_ctrl_wb_seq : self-checking bench for ctrl_wb_seq.
// A table of pass descriptions drives full write-back passes. The expected
// write stream for each pass is pushed to a queue when start is driven and is
// popped on every accepted write. A few hand-written sequences cover the
// start/abort interactions in IDLE and LOAD.
// ----------------------------------------------------------------------------
module tb_ctrl_wb_seq;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic       abort;
   logic [2:0] n_mux;
   logic [3:0] n_groups;
   logic [7:0] base_addr;
   logic       mem_ready;
   logic       busy;
   logic       done;
   logic       cnt_load;
   logic [2:0] max_val;
   logic       cnt_clear;
   logic       act_wb;
   logic [1:0] sel_mux_out;
   logic [3:0] sel_relu;
   logic       wr_en;
   logic [7:0] wr_addr;

   always #5 clk = ~clk;

   ctrl_wb_seq #(.ADDR_W(8), .GRP_W(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .abort       (abort),
      .n_mux       (n_mux),
      .n_groups    (n_groups),
      .base_addr   (base_addr),
      .mem_ready   (mem_ready),
      .busy        (busy),
      .done        (done),
      .cnt_load    (cnt_load),
      .max_val     (max_val),
      .cnt_clear   (cnt_clear),
      .act_wb      (act_wb),
      .sel_mux_out (sel_mux_out),
      .sel_relu    (sel_relu),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr)
   );

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [7:0] addr;
      logic [1:0] mux;
      logic [3:0] relu;
   } wr_t;

   wr_t exp_q[$];

   typedef struct {
      logic [2:0] nm;
      logic [3:0] ng;
      logic [7:0] ba;
      int stall_start;
      int stall_len;
      int abort_at;
      int restart_at;
      int rst_at;
   } pass_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " busy"},      32'(busy), 0);
      check({tag, " done"},      32'(done), 0);
      check({tag, " cnt_load"},  32'(cnt_load), 0);
      check({tag, " cnt_clear"}, 32'(cnt_clear), 0);
      check({tag, " act_wb"},    32'(act_wb), 0);
      check({tag, " wr_en"},     32'(wr_en), 0);
      check({tag, " max_val"},   32'(max_val), 0);
      check({tag, " sel_mux"},   32'(sel_mux_out), 0);
      check({tag, " sel_relu"},  32'(sel_relu), 0);
      check({tag, " wr_addr"},   32'(wr_addr), 0);
   endtask

   task automatic run_pass(input int idx, input pass_t p);
      int nmc, grps, nwords, t0, stalls, c;
      wr_t w;
      bit ended;
      nmc    = (p.nm == 3'd0) ? 1 : ((p.nm > 3'd4) ? 4 : int'(p.nm));
      grps   = (p.ng == 4'd0) ? 16 : int'(p.ng);
      nwords = nmc * grps;
      stalls = 0;
      ended  = 0;

      // Cycle T: start in IDLE; the expected stream is queued now.
      @(negedge clk);
      start = 1'b1; abort = 1'b0; mem_ready = 1'b1;
      n_mux = p.nm; n_groups = p.ng; base_addr = p.ba;
      for (int i = 0; i < nwords; i++) begin
         w.addr = p.ba + 8'(i);
         w.mux  = 2'(i % nmc);
         w.relu = 4'(i / nmc);
         exp_q.push_back(w);
      end
      t0 = cyc;
      #1;
      check("idle busy", 32'(busy), 0);

      // T+1: LOAD
      @(negedge clk);
      start = 1'b0;
      #1;
      check("load cnt_load", 32'(cnt_load), 1);
      check("load max_val", 32'(max_val), 32'(nmc));
      check("load busy", 32'(busy), 1);

      // T+2: CLEAR
      @(negedge clk);
      #1;
      check("clear cnt_clear", 32'(cnt_clear), 1);
      check("clear wr_en", 32'(wr_en), 0);

      // WB cycles
      c = 0;
      while (exp_q.size() > 0) begin
         if (c > 200) begin
            check("wb timeout", 32'(exp_q.size()), 0);
            exp_q.delete();
            ended = 1;
            break;
         end
         @(negedge clk);
         mem_ready = !(c >= p.stall_start && c < p.stall_start + p.stall_len);
         abort     = (c == p.abort_at);
         start     = (c == p.restart_at);
         if (c == p.restart_at) begin
            n_mux = 3'd1; n_groups = 4'd3; base_addr = 8'hC0;
         end
         #1;
         if (c == p.rst_at) begin
            rst_n = 1'b0;
            #1;
            check_all_zero("async reset");
            exp_q.delete();
            @(negedge clk);
            rst_n = 1'b1; start = 1'b0; mem_ready = 1'b1;
            ended = 1;
            break;
         end
         if (abort) begin
            check("abort cnt_clear", 32'(cnt_clear), 1);
            check("abort wr_en", 32'(wr_en), 0);
            check("abort act_wb", 32'(act_wb), 0);
            exp_q.delete();
            @(negedge clk);
            abort = 1'b0;
            #1;
            check("post-abort busy", 32'(busy), 0);
            check("post-abort done", 32'(done), 0);
            ended = 1;
            break;
         end
         check("wb wr_en", 32'(wr_en), 1);
         w = exp_q[0];
         check("wb wr_addr", 32'(wr_addr), 32'(w.addr));
         check("wb sel_mux_out", 32'(sel_mux_out), 32'(w.mux));
         check("wb sel_relu", 32'(sel_relu), 32'(w.relu));
         check("wb done", 32'(done), 0);
         if (mem_ready) begin
            check("wb act_wb", 32'(act_wb), 1);
            void'(exp_q.pop_front());
         end else begin
            check("stall act_wb", 32'(act_wb), 0);
            stalls++;
         end
         c++;
      end

      if (!ended) begin
         @(negedge clk);
         start = 1'b0; abort = 1'b0; mem_ready = 1'b1;
         #1;
         check("done pulse", 32'(done), 1);
         check("done busy", 32'(busy), 1);
         check("done wr_en", 32'(wr_en), 0);
         check("done latency", 32'(cyc - t0), 32'(3 + nwords + stalls));
         @(negedge clk);
         #1;
         check("after done", 32'(done), 0);
         check("after busy", 32'(busy), 0);
      end
      $display("pass %0d: n_mux=%0d n_groups=%0d base=0x%02h words=%0d stalls=%0d cmp=%0d err=%0d",
               idx, p.nm, p.ng, p.ba, nwords, stalls, n_cmp, n_err);
   endtask

   pass_t tbl[11];

   initial begin
      #20000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      //          nm    ng    ba     st  sl  abort rest rst
      tbl[0]  = '{3'd4, 4'd2, 8'h10, -1, 0,  -1,   -1,  -1};
      tbl[1]  = '{3'd3, 4'd1, 8'h20,  1, 3,  -1,   -1,  -1};
      tbl[2]  = '{3'd0, 4'd3, 8'h30, -1, 0,  -1,   -1,  -1};
      tbl[3]  = '{3'd7, 4'd2, 8'h40, -1, 0,  -1,   -1,  -1};
      tbl[4]  = '{3'd4, 4'd1, 8'hFE, -1, 0,  -1,   -1,  -1};
      tbl[5]  = '{3'd2, 4'd2, 8'h50, -1, 0,   2,   -1,  -1};
      tbl[6]  = '{3'd2, 4'd2, 8'h50,  3, 2,  -1,   -1,  -1};
      tbl[7]  = '{3'd3, 4'd2, 8'h60, -1, 0,  -1,    2,  -1};
      tbl[8]  = '{3'd1, 4'd0, 8'h70,  5, 1,  -1,   -1,  -1};
      tbl[9]  = '{3'd4, 4'd3, 8'h80, -1, 0,  -1,   -1,   3};
      tbl[10] = '{3'd2, 4'd1, 8'h90, -1, 0,  -1,   -1,  -1};

      rst_n = 1'b0; start = 1'b0; abort = 1'b0; mem_ready = 1'b1;
      n_mux = 3'd0; n_groups = 4'd0; base_addr = 8'h00;
      #12;
      check_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 11; i++) begin
         run_pass(i, tbl[i]);
      end

      // start and abort together in IDLE: start wins.
      @(negedge clk);
      start = 1'b1; abort = 1'b1; n_mux = 3'd2; n_groups = 4'd1; base_addr = 8'hA0;
      #1;
      check("idle abort busy", 32'(busy), 0);
      // abort in LOAD: clear strobe instead of load, back to IDLE.
      @(negedge clk);
      start = 1'b0; abort = 1'b1;
      #1;
      check("load+abort busy", 32'(busy), 1);
      check("load+abort cnt_clear", 32'(cnt_clear), 1);
      check("load+abort cnt_load", 32'(cnt_load), 0);
      @(negedge clk);
      #1;
      check("load-abort idle", 32'(busy), 0);
      check("load-abort done", 32'(done), 0);
      // abort alone in IDLE is ignored.
      @(negedge clk);
      #1;
      check("idle abort strobe", 32'(cnt_clear), 0);
      @(negedge clk);
      abort = 1'b0;
      #1;
      check("idle abort stays idle", 32'(busy), 0);
      $display("hand sequences: cmp=%0d err=%0d", n_cmp, n_err);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
